bin2bcd_seq: RTL and testbench
==============================

Name: bin2bcd_seq

Overview:
Sequential binary-to-BCD converter that feeds a bank of 7-segment decoders directly. Each decoder takes one 4-bit nibble plus an enable.
- Accepts one IN_W-bit unsigned value per valid/ready handshake.
- Converts it iteratively using shift-and-add-3 (double dabble).
- Presents DIGITS BCD nibbles, plus a per-digit enable mask for optional leading-zero blanking, held stable between conversions.

Parameters:
IN_W, 16, width of the binary input.
DIGITS, 5, number of BCD digits produced. Must satisfy 10^DIGITS >= 2^IN_W; an elaboration-time check fails otherwise.

Ports:
clk  input  1  clock; all state changes on the rising edge.
rst  input  1  synchronous, active-high reset.
in_valid  input  1  in_data and blank_lz are valid.
in_ready  output  1  converter idle and able to accept.
in_data  input  IN_W  unsigned binary value.
blank_lz  input  1  enable leading-zero blanking for this conversion; sampled with in_data.
out_valid  output  1  conversion result available.
out_ready  input  1  consumer acknowledges result.
bcd  output  4*DIGITS  digit i in bits [4i+3:4i], digit 0 least significant.
en  output  DIGITS  per-digit display enable, bit i pairs with digit i.

Behaviour:
- Reset state (first cycle after rst high): state IDLE, in_ready=1, out_valid=0, bcd=0, en=1 (only digit 0 enabled). Scratch registers and iteration counter are cleared.
- States: IDLE, SHIFT, DONE.
- in_ready = (state==IDLE), decoded from the state register; no combinational path from any input.
- out_valid = (state==DONE), registered.
- IDLE: on in_valid, at edge k:
  - load shift register with in_data and clear the BCD scratch;
  - latch blank_lz and reset the counter to 0;
  - go to SHIFT.
- SHIFT, once per cycle:
  - each scratch digit >=5 has 3 added (4-bit, no carry out);
  - then {scratch, shift} shifts left by 1;
  - the counter increments.
- After the IN_W-th shift (edge k+IN_W):
  - bcd is loaded with the final scratch;
  - en is computed;
  - state goes to DONE.
  - out_valid is first high in the cycle after edge k+IN_W. Latency from acceptance is exactly IN_W cycles.
- DONE: out_valid=1, bcd/en stable. On out_valid && out_ready → IDLE at that edge. No new input is accepted in the same cycle; minimum input spacing is IN_W+2 cycles.
- bcd/en persist after handoff and while the next conversion runs. They update only at completion, so a downstream display never flickers.
- Blanking rule:
  - en[0]=1 always;
  - for i>=1, en[i]=0 iff the latched blank_lz=1 and digits i..DIGITS-1 are all zero; otherwise en[i]=1;
  - with latched blank_lz=0, en is all ones.
- in_data and blank_lz are ignored outside an IDLE handshake. Changing them mid-conversion has no effect.
- out_ready is ignored outside DONE.
- rst during SHIFT or DONE aborts the conversion. Next cycle: reset values, and the pending result is discarded.
- rst has priority over a simultaneous handshake.
- Counter width is clog2(IN_W+1); no wrap within a conversion.

Decomposition:
- Shared package bin2bcd_pkg:
  - state enum {IDLE, SHIFT, DONE};
  - BCD_DIGIT_W=4 constant;
  - ADD3_THRESH=5 constant;
  - function computing the minimum DIGITS for a given IN_W, used by the elaboration check.
- Sub-module bcd_add3: combinational, 4-bit in, 4-bit out, adds 3 when in >= 5. Instantiated DIGITS times via generate.

Test Plan:
- Reset, then in_data=0 with blank_lz=1 → out_valid after 16 cycles; bcd=0x00000, en=5'b00001.
- in_data=65535, blank_lz=0 → bcd=0x65535, en=5'b11111; out_valid rises exactly 16 cycles after the accept edge; in_ready=0 throughout.
- in_data=1234, blank_lz=1 → bcd=0x01234, en=5'b01111. Repeat with blank_lz=0 → en=5'b11111.
- Backpressure: hold out_ready=0 for 10 cycles in DONE → out_valid, bcd and en stay constant, and in_valid is not accepted. Raising out_ready → IDLE next cycle; bcd is retained.
- Reset mid-conversion: assert rst at SHIFT cycle 8 → next cycle out_valid=0, bcd=0, en=5'b00001, in_ready=1. A following conversion of 42 → bcd=0x00042.
- Back-to-back with in_valid held high: 9, 10, 99999-clipped-to-65535 → each result correct, with accepts exactly IN_W+2 cycles apart.

Source files
------------

// File: rtl/bin2bcd_pkg.sv
// Shared types and constants for the sequential binary-to-BCD converter.
package bin2bcd_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

  localparam int BCD_DIGIT_W = 4;
  localparam int ADD3_THRESH = 5;

  // Smallest digit count with 10^d >= 2^in_w, i.e. ceil(in_w * log10(2)).
  // 2^n is never an exact power of ten for n > 0, so the fixed-point
  // approximation of log10(2) cannot land on a false boundary.
  function automatic int min_digits(input int in_w);
    int d;
    d = (in_w * 30103 + 99999) / 100000;
    if (d < 1) d = 1;
    return d;
  endfunction

endpackage

// File: rtl/bcd_add3.sv
// Double-dabble digit correction: add 3 to a BCD digit that is 5 or more.
module bcd_add3
  import bin2bcd_pkg::*;
(
  input  logic [BCD_DIGIT_W-1:0] d_i,
  output logic [BCD_DIGIT_W-1:0] d_o
);

  // 4-bit add, no carry out; a valid BCD digit plus 3 never exceeds 12.
  assign d_o = (d_i >= BCD_DIGIT_W'(ADD3_THRESH)) ? d_i + BCD_DIGIT_W'(3) : d_i;

endmodule

// File: rtl/bin2bcd_seq.sv
// Iterative binary-to-BCD converter (one shift per cycle) with a
// valid/ready front end and a held result plus leading-zero enable mask.
module bin2bcd_seq
  import bin2bcd_pkg::*;
#(
  parameter int IN_W   = 16,
  parameter int DIGITS = 5
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [IN_W-1:0]             in_data,
  input  logic                        blank_lz,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [BCD_DIGIT_W*DIGITS-1:0] bcd,
  output logic [DIGITS-1:0]           en
);

  localparam int BW    = BCD_DIGIT_W * DIGITS;
  localparam int CNT_W = $clog2(IN_W + 1);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(IN_W - 1);

  if (DIGITS < min_digits(IN_W)) begin : g_digits_chk
    $error("bin2bcd_seq: DIGITS too small for IN_W");
  end

  state_e           state_q, state_d;
  logic [IN_W-1:0]  shift_q, shift_d;
  logic [BW-1:0]    scratch_q, scratch_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             blank_q, blank_d;
  logic [BW-1:0]    bcd_q, bcd_d;
  logic [DIGITS-1:0] en_q, en_d;

  logic [BW-1:0]      adj;
  logic [BW+IN_W-1:0] shifted;
  logic [DIGITS-1:0]  en_fin;
  logic               allz;

  for (genvar i = 0; i < DIGITS; i++) begin : g_add3
    bcd_add3 u_add3 (
      .d_i (scratch_q[i*BCD_DIGIT_W +: BCD_DIGIT_W]),
      .d_o (adj[i*BCD_DIGIT_W +: BCD_DIGIT_W])
    );
  end

  assign shifted = {adj, shift_q} << 1;

  // Display enables for the digits produced by the final shift.
  always_comb begin
    en_fin = '1;
    allz   = 1'b1;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      allz = allz & (shifted[IN_W + i*BCD_DIGIT_W +: BCD_DIGIT_W] == '0);
      if (blank_q && allz) en_fin[i] = 1'b0;
    end
  end

  // Next-state and datapath updates for the IDLE/SHIFT/DONE sequence.
  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    scratch_d = scratch_q;
    cnt_d     = cnt_q;
    blank_d   = blank_q;
    bcd_d     = bcd_q;
    en_d      = en_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          shift_d   = in_data;
          scratch_d = '0;
          blank_d   = blank_lz;
          cnt_d     = '0;
          state_d   = SHIFT;
        end
      end
      SHIFT: begin
        {scratch_d, shift_d} = shifted;
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == LAST) begin
          bcd_d   = shifted[IN_W +: BW];
          en_d    = en_fin;
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State register; reset wins over any handshake in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      shift_q   <= '0;
      scratch_q <= '0;
      cnt_q     <= '0;
      blank_q   <= 1'b0;
      bcd_q     <= '0;
      en_q      <= DIGITS'(1);
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      scratch_q <= scratch_d;
      cnt_q     <= cnt_d;
      blank_q   <= blank_d;
      bcd_q     <= bcd_d;
      en_q      <= en_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign bcd       = bcd_q;
  assign en        = en_q;

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Bench for bin2bcd_seq: vector table, random values against a decimal
// model, and hand-written backpressure / reset / back-to-back sequences.
module tb_bin2bcd_seq;

  localparam int IN_W   = 16;
  localparam int DIGITS = 5;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_data;
  logic        blank_lz;
  logic        out_valid;
  logic        out_ready;
  logic [19:0] bcd;
  logic [4:0]  en;

  int n_vec = 0;
  int n_bad = 0;
  int cyc   = 0;
  bit mon_en = 1'b0;
  int acc_q[$];
  logic [19:0] res_q[$];

  bin2bcd_seq #(.IN_W(IN_W), .DIGITS(DIGITS)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .blank_lz  (blank_lz),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .bcd       (bcd),
    .en        (en)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (mon_en && in_valid && in_ready) acc_q.push_back(cyc);
    if (mon_en && out_valid && out_ready) res_q.push_back(bcd);
  end

  typedef struct {
    logic [15:0] d;
    bit          bl;
    logic [19:0] bcd;
    logic [4:0]  en;
  } vec_t;

  // Decimal digits of v, least significant first.
  function automatic logic [19:0] ref_bcd(input int v);
    logic [19:0] r;
    int t;
    t = v;
    for (int i = 0; i < DIGITS; i++) begin
      r[i*4 +: 4] = 4'(t % 10);
      t = t / 10;
    end
    return r;
  endfunction

  // Enable only as many digits as the number has significant digits.
  function automatic logic [4:0] ref_en(input int v, input bit bl);
    int nd, t;
    nd = 1;
    t  = v;
    while (t >= 10) begin
      nd++;
      t = t / 10;
    end
    if (!bl) return 5'b11111;
    return 5'((1 << nd) - 1);
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // One conversion; optionally releases the result right after checking it.
  task automatic conv(input logic [15:0] d, input bit bl, input logic [19:0] eb,
                      input logic [4:0] ee, input bit release_it, input string tag);
    int  lat, w;
    bit  rdy_err;
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = d;
    blank_lz = bl;
    w = 0;
    while (!in_ready && w < 100) begin
      @(negedge clk);
      w++;
    end
    chk({tag, " accept"}, {31'd0, in_ready}, 32'd1);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    in_data  = 16'hxxxx;
    blank_lz = 1'b0;
    lat = 0;
    rdy_err = 1'b0;
    while (!out_valid && lat < 200) begin
      if (in_ready) rdy_err = 1'b1;
      @(negedge clk);
      lat++;
    end
    chk({tag, " latency"}, lat, IN_W);
    chk({tag, " busy"}, {31'd0, rdy_err}, 32'd0);
    chk({tag, " bcd"}, {12'd0, bcd}, {12'd0, eb});
    chk({tag, " en"}, {27'd0, en}, {27'd0, ee});
    if (release_it) begin
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
    end
  endtask

  vec_t tbl[$];

  initial begin
    logic [19:0] held_bcd;
    logic [4:0]  held_en;
    int v, w;
    bit bl;
    int vals[3];

    rst = 1'b1; in_valid = 1'b0; in_data = '0; blank_lz = 1'b0; out_ready = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("reset in_ready", {31'd0, in_ready}, 32'd1);
    chk("reset out_valid", {31'd0, out_valid}, 32'd0);
    chk("reset bcd", {12'd0, bcd}, 32'd0);
    chk("reset en", {27'd0, en}, 32'd1);

    tbl.push_back('{16'd0,     1'b1, 20'h00000, 5'b00001});
    tbl.push_back('{16'd65535, 1'b0, 20'h65535, 5'b11111});
    tbl.push_back('{16'd1234,  1'b1, 20'h01234, 5'b01111});
    tbl.push_back('{16'd1234,  1'b0, 20'h01234, 5'b11111});
    tbl.push_back('{16'd42,    1'b1, 20'h00042, 5'b00011});
    tbl.push_back('{16'd10000, 1'b1, 20'h10000, 5'b11111});
    tbl.push_back('{16'd9,     1'b1, 20'h00009, 5'b00001});
    tbl.push_back('{16'd100,   1'b0, 20'h00100, 5'b11111});
    tbl.push_back('{16'd5,     1'b1, 20'h00005, 5'b00001});
    foreach (tbl[i])
      conv(tbl[i].d, tbl[i].bl, tbl[i].bcd, tbl[i].en, 1'b1, $sformatf("tbl%0d", i));

    for (int i = 0; i < 20; i++) begin
      v  = int'($urandom_range(0, 65535));
      bl = 1'($urandom_range(0, 1));
      conv(16'(v), bl, ref_bcd(v), ref_en(v, bl), 1'b1, $sformatf("rnd%0d", i));
    end
    chk("handoff in_ready", {31'd0, in_ready}, 32'd1);
    chk("handoff bcd kept", {12'd0, bcd}, {12'd0, ref_bcd(v)});

    // Backpressure: result held, no new accept while DONE.
    conv(16'd777, 1'b1, 20'h00777, 5'b00111, 1'b0, "bp");
    held_bcd = bcd;
    held_en  = en;
    in_valid = 1'b1;
    in_data  = 16'd31;
    blank_lz = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("bp out_valid", {31'd0, out_valid}, 32'd1);
      chk("bp in_ready", {31'd0, in_ready}, 32'd0);
      chk("bp bcd", {12'd0, bcd}, {12'd0, held_bcd});
      chk("bp en", {27'd0, en}, {27'd0, held_en});
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("bp release idle", {31'd0, in_ready}, 32'd1);
    chk("bp release valid", {31'd0, out_valid}, 32'd0);
    chk("bp bcd retained", {12'd0, bcd}, 32'h00777);

    // Reset in the middle of a conversion.
    @(negedge clk);
    in_valid = 1'b1; in_data = 16'd5555; blank_lz = 1'b0;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (7) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midrst out_valid", {31'd0, out_valid}, 32'd0);
    chk("midrst bcd", {12'd0, bcd}, 32'd0);
    chk("midrst en", {27'd0, en}, 32'd1);
    chk("midrst in_ready", {31'd0, in_ready}, 32'd1);
    repeat (20) @(negedge clk);
    chk("midrst no result", {31'd0, out_valid}, 32'd0);
    conv(16'd42, 1'b0, 20'h00042, 5'b11111, 1'b1, "post_rst");

    // Back-to-back with in_valid and out_ready held high.
    vals[0] = 9; vals[1] = 10; vals[2] = (99999 > 65535) ? 65535 : 99999;
    acc_q.delete();
    res_q.delete();
    @(negedge clk);
    mon_en = 1'b1;
    out_ready = 1'b1;
    in_valid = 1'b1;
    blank_lz = 1'b1;
    for (int j = 0; j < 3; j++) begin
      in_data = 16'(vals[j]);
      w = 0;
      while (acc_q.size() < j + 1 && w < 100) begin
        @(negedge clk);
        w++;
      end
    end
    in_valid = 1'b0;
    w = 0;
    while (res_q.size() < 3 && w < 100) begin
      @(negedge clk);
      w++;
    end
    mon_en = 1'b0;
    out_ready = 1'b0;
    chk("b2b accepts", acc_q.size(), 3);
    chk("b2b results", res_q.size(), 3);
    if (acc_q.size() == 3) begin
      chk("b2b spacing0", acc_q[1] - acc_q[0], IN_W + 2);
      chk("b2b spacing1", acc_q[2] - acc_q[1], IN_W + 2);
    end
    for (int j = 0; j < 3; j++)
      if (j < res_q.size())
        chk($sformatf("b2b bcd%0d", j), {12'd0, res_q[j]}, {12'd0, ref_bcd(vals[j])});
    chk("b2b en", {27'd0, en}, {27'd0, ref_en(vals[2], 1'b1)});

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
